// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
// Holds the FSM state encoding, the requester count and the one-hot
// grant encodings. The arbiter, its interface and its testbench all
// import this package.
package arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [NUM_REQ-1:0] GRANT_NONE = 2'b00;
  localparam logic [NUM_REQ-1:0] GRANT_0    = 2'b01;
  localparam logic [NUM_REQ-1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/arb_if.sv
// Arbiter interface bundle.
// Ports:
//   clk : input, the arbiter clock.
// Signals:
//   rst     : asynchronous active-low reset.
//   request : one bit per requester.
//   grant   : one-hot-or-zero ownership, driven by the arbiter.
// The dut modport presents the arbiter's view of the bundle.
interface arb_if
  import arb_pkg::*;
(
  input logic clk
);

  logic               rst;
  logic [NUM_REQ-1:0] request;
  logic [NUM_REQ-1:0] grant;

  modport dut (
    input  clk,
    input  rst,
    input  request,
    output grant
  );

endinterface

// File: rtl/rr_arbiter.sv
// Two-requester round-robin arbiter with a bounded hold time.
// A requester keeps the grant while it asks for it; when both ask, the
// owner yields after MAX_HOLD consecutive cycles. Ownership is handed
// straight from one requester to the other without an idle cycle.
// Parameters:
//   MAX_HOLD : consecutive grant cycles (1..15) before a contended yield.
// Ports:
//   clk     : input, clock; all state changes on its rising edge.
//   rst     : input, asynchronous active-low reset.
//   request : input [1:0], request[i] high when requester i wants access.
//   grant   : output [1:0], registered one-hot-or-zero grant.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] request,
  output logic [NUM_REQ-1:0] grant
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] hold;
  logic [3:0] hold_next;
  logic       last_served;
  logic       last_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      hold        <= '0;
      last_served <= 1'b1;
    end else begin
      state       <= state_next;
      hold        <= hold_next;
      last_served <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold;
    last_next  = last_served;

    unique case (state)
      IDLE: begin
        unique case (request)
          2'b01:   state_next = GNT0;
          2'b10:   state_next = GNT1;
          2'b11:   state_next = last_served ? GNT0 : GNT1;
          default: state_next = IDLE;
        endcase
      end
      GNT0: begin
        if (!request[0]) begin
          state_next = request[1] ? GNT1 : IDLE;
        end else if (request[1] && (hold == HOLD_LAST)) begin
          state_next = GNT1;
        end
      end
      GNT1: begin
        if (!request[1]) begin
          state_next = request[0] ? GNT0 : IDLE;
        end else if (request[0] && (hold == HOLD_LAST)) begin
          state_next = GNT0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Any state change restarts the hold count; staying in a grant state
    // counts up and parks at HOLD_LAST, so an uncontended owner that later
    // sees contention yields at the very next edge.
    if (state_next != state) begin
      hold_next = '0;
    end else if ((state != IDLE) && (hold != HOLD_LAST)) begin
      hold_next = hold + 4'd1;
    end

    if (state_next == GNT0) begin
      last_next = 1'b0;
    end else if (state_next == GNT1) begin
      last_next = 1'b1;
    end
  end

  // Grant comes from the state register only, so reset clears it at once.
  always_comb begin
    grant = GRANT_NONE;
    unique case (state)
      GNT0:    grant = GRANT_0;
      GNT1:    grant = GRANT_1;
      default: grant = GRANT_NONE;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: a main instance with MAX_HOLD = 4
// on the arbiter interface and a second instance with MAX_HOLD = 1.
module tb_rr_arbiter;
  import arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  arb_if u_if (.clk(clk));

  logic [1:0] req_b;
  logic [1:0] grant_b;

  rr_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk     (u_if.clk),
    .rst     (u_if.rst),
    .request (u_if.request),
    .grant   (u_if.grant)
  );

  rr_arbiter #(.MAX_HOLD(1)) u_dut_b (
    .clk     (clk),
    .rst     (u_if.rst),
    .request (req_b),
    .grant   (grant_b)
  );

  int unsigned check_cnt = 0;
  int unsigned pass_cnt  = 0;

  logic [1:0] exp_q[$];

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
  endtask

  // Drive one request at the falling edge, queue its expected grant and
  // compare it just after the following rising edge.
  task automatic drive(input string name, input logic sel, input logic [1:0] req,
                       input logic [1:0] exp);
    logic [1:0] e;
    @(negedge clk);
    if (sel) req_b = req;
    else     u_if.request = req;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, sel ? grant_b : u_if.grant, e);
  endtask

  // Per-cycle invariants: one-hot-or-zero, and no grant without a request
  // at the edge that produced it.
  logic [1:0] prev_a = '0;
  logic [1:0] prev_b = '0;
  always @(posedge clk) begin
    prev_a = u_if.request;
    prev_b = req_b;
  end
  always @(negedge clk) begin
    check("onehot0_a", {1'b0, $onehot0(u_if.grant)}, 2'b01);
    check("onehot0_b", {1'b0, $onehot0(grant_b)}, 2'b01);
    check("grant_wo_req_a", u_if.grant & ~prev_a, 2'b00);
    check("grant_wo_req_b", grant_b & ~prev_b, 2'b00);
  end

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{2'b00, GRANT_NONE};
    vecs[1]  = '{2'b01, GRANT_0};
    vecs[2]  = '{2'b01, GRANT_0};
    vecs[3]  = '{2'b10, GRANT_1};    // handover without bubble
    vecs[4]  = '{2'b00, GRANT_NONE};
    vecs[5]  = '{2'b11, GRANT_0};    // tie after reset goes to requester 0
    vecs[6]  = '{2'b11, GRANT_0};
    vecs[7]  = '{2'b11, GRANT_0};
    vecs[8]  = '{2'b11, GRANT_0};
    vecs[9]  = '{2'b11, GRANT_1};    // forced yield after 4 cycles
    vecs[10] = '{2'b11, GRANT_1};
    vecs[11] = '{2'b11, GRANT_1};
    vecs[12] = '{2'b11, GRANT_1};
    vecs[13] = '{2'b11, GRANT_0};    // yield back 4 cycles later
    vecs[14] = '{2'b10, GRANT_1};
    vecs[15] = '{2'b01, GRANT_0};
    vecs[16] = '{2'b00, GRANT_NONE};
    vecs[17] = '{2'b11, GRANT_1};    // last served was 0, tie goes to 1
    vecs[18] = '{2'b01, GRANT_0};
    vecs[19] = '{2'b00, GRANT_NONE};

    u_if.rst     = 1'b0;
    u_if.request = 2'b00;
    req_b        = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", u_if.grant, GRANT_NONE);
    check("reset_b", grant_b, GRANT_NONE);
    #2 u_if.rst = 1'b1;

    for (int i = 0; i < 20; i++) drive($sformatf("vec%0d", i), 1'b0, vecs[i].req, vecs[i].exp);

    // Long uncontended hold, then contention must yield at once.
    for (int i = 0; i < 20; i++) drive("hold_solo", 1'b0, 2'b01, GRANT_0);
    drive("sat_yield", 1'b0, 2'b11, GRANT_1);
    for (int i = 0; i < 3; i++) drive("gnt1_hold", 1'b0, 2'b11, GRANT_1);
    drive("gnt1_yield", 1'b0, 2'b11, GRANT_0);
    drive("to_idle", 1'b0, 2'b00, GRANT_NONE);

    // Asynchronous reset in the middle of a GNT1 cycle.
    drive("enter_gnt1", 1'b0, 2'b10, GRANT_1);
    @(negedge clk);
    #3 u_if.rst = 1'b0;
    #1 check("async_rst_drop", u_if.grant, GRANT_NONE);
    u_if.request = 2'b11;
    @(posedge clk);
    #1 check("rst_held", u_if.grant, GRANT_NONE);
    #2 u_if.rst = 1'b1;
    drive("post_rst_tie", 1'b0, 2'b11, GRANT_0);
    for (int i = 0; i < 3; i++) drive("post_rst_hold", 1'b0, 2'b11, GRANT_0);
    drive("post_rst_yield", 1'b0, 2'b11, GRANT_1);
    drive("idle_again", 1'b0, 2'b00, GRANT_NONE);

    // MAX_HOLD = 1 alternates every cycle under contention.
    drive("mh1_a", 1'b1, 2'b11, GRANT_0);
    drive("mh1_b", 1'b1, 2'b11, GRANT_1);
    drive("mh1_c", 1'b1, 2'b11, GRANT_0);
    drive("mh1_d", 1'b1, 2'b11, GRANT_1);
    drive("mh1_solo", 1'b1, 2'b01, GRANT_0);
    drive("mh1_stay", 1'b1, 2'b01, GRANT_0);
    drive("mh1_idle", 1'b1, 2'b00, GRANT_NONE);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
